// File: rtl/soc_system_mem_pkg.sv
// Shared types and sizes for the on-chip memory copy/fill master.
// Word addressing on a 64-bit Avalon-MM slave.
package soc_system_mem_pkg;

  localparam int DATA_W     = 64;
  localparam int WADDR_W    = 13;
  localparam int LEN_W      = 14;
  localparam int BE_W       = DATA_W / 8;
  localparam int BADDR_W    = WADDR_W + 3;
  localparam int BYTE_SHIFT = 3;

  localparam logic [BE_W-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  function automatic logic [BADDR_W-1:0] word2byte(
    input logic [WADDR_W-1:0] w
  );
    return BADDR_W'(w) << BYTE_SHIFT;
  endfunction

endpackage

// File: rtl/soc_system_mem_copy_master.sv
// Avalon-MM master doing word-granular COPY or FILL,
// one outstanding transfer at a time.
module soc_system_mem_copy_master
  import soc_system_mem_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_fill,
  input  logic [WADDR_W-1:0] cmd_src,
  input  logic [WADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [DATA_W-1:0]  cmd_pattern,
  output logic               busy,
  output logic               done,
  output logic [LEN_W-1:0]   words_done,
  output logic [BADDR_W-1:0] avm_address,
  output logic               avm_read,
  output logic               avm_write,
  output logic [BE_W-1:0]    avm_byteenable,
  output logic [DATA_W-1:0]  avm_writedata,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  input  logic               avm_waitrequest
);

  state_e               state_q, state_d;
  logic [WADDR_W-1:0]   src_q, src_d;
  logic [WADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 fill_q, fill_d;
  logic [LEN_W-1:0]     cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    fill_d  = fill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          fill_d = cmd_fill;
          cnt_d  = '0;
          // FILL keeps the pattern in the write-data register for the whole run
          if (cmd_fill) wdata_d = cmd_pattern;
          if (cmd_len == '0)  state_d = ST_DONE;
          else if (cmd_fill)  state_d = ST_WR_REQ;
          else                state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          wdata_d = avm_readdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          cnt_d = cnt_inc;
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          if (cnt_inc == len_q) state_d = ST_DONE;
          else if (fill_q)      state_d = ST_WR_REQ;
          else                  state_d = ST_RD_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign words_done = cnt_q;

  assign avm_read       = (state_q == ST_RD_REQ);
  assign avm_write      = (state_q == ST_WR_REQ);
  assign avm_byteenable = (avm_read || avm_write) ? BE_ALL : '0;
  assign avm_writedata  = wdata_q;
  assign avm_address    = avm_read  ? word2byte(src_q) :
                          avm_write ? word2byte(dst_q) : '0;

endmodule
